io_port_controller: RTL and testbench

- Peripheral-side counterpart of the pipeline processor's I/O interface. It drives the processor's in_port and interrupt inputs and consumes its out_port.
- Inbound: an external device pushes words through a valid/ready handshake into a small FIFO. The head word is presented on in_port, and interrupt is raised to request service.
- Outbound: a processor OUT write strobe captures out_port into a one-entry holding register. The register drains to the device through a valid/ready handshake.

---
 rtl/io_pkg.sv | 14 +
 rtl/io_in_fifo.sv | 69 ++++++
 rtl/io_port_controller.sv | 126 ++++++++++++
 tb/tb_io_port_controller.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared types and default sizing for the processor I/O port controller.
package io_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RAISE = 2'd1,
      WAIT  = 2'd2
   } irq_state_t;

   localparam int DEF_W          = 16;
   localparam int DEF_DEPTH      = 4;
   localparam int DEF_IRQ_CYCLES = 2;

endpackage

// File: rtl/io_in_fifo.sv
// Inbound word FIFO with first-word fall-through head; head reads as 0 when empty.
module io_in_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [W-1:0]               wr_data,
   input  logic                       wr_en,
   input  logic                       rd_en,
   output logic [W-1:0]               rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic [AW:0]   count_next;
   logic          push;
   logic          pop;

   assign full  = (count_reg == (AW+1)'(DEPTH));
   assign empty = (count_reg == '0);
   assign push  = wr_en && !full;
   assign pop   = rd_en && !empty;

   // Storage holds no reset: stale entries are never visible past the empty mask.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (push && (wr_ptr_reg == AW'(gi)))
               mem[gi] <= wr_data;
         end
      end
   endgenerate

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_next;
      end
   end

   assign rd_data = empty ? '0 : mem[rd_ptr_reg];
   assign count   = count_reg;

endmodule

// File: rtl/io_port_controller.sv
// Peripheral side of the processor I/O interface: inbound FIFO with interrupt
// request, and a one-entry outbound holding register with sticky overflow.
import io_pkg::*;

module io_port_controller #(
   parameter int W          = DEF_W,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int IRQ_CYCLES = DEF_IRQ_CYCLES
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [W-1:0]            dev_in_data,
   input  logic                    dev_in_valid,
   output logic                    dev_in_ready,
   output logic [W-1:0]            in_port,
   input  logic                    in_rd,
   output logic                    interrupt,
   input  logic [W-1:0]            out_port,
   input  logic                    out_wr,
   output logic [W-1:0]            dev_out_data,
   output logic                    dev_out_valid,
   input  logic                    dev_out_ready,
   output logic                    out_ovf,
   output logic [$clog2(DEPTH):0]  in_count
);

   localparam int CW = (IRQ_CYCLES > 1) ? $clog2(IRQ_CYCLES) : 1;

   logic       full;
   logic       empty;
   logic       pop;

   irq_state_t state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic       srv_reg, srv_next;
   logic       irq_reg;

   logic [W-1:0] out_data_reg;
   logic         out_valid_reg;
   logic         ovf_reg;

   io_in_fifo #(
      .W     (W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_data (dev_in_data),
      .wr_en   (dev_in_valid),
      .rd_en   (in_rd),
      .rd_data (in_port),
      .full    (full),
      .empty   (empty),
      .count   (in_count)
   );

   assign dev_in_ready = !full;
   assign pop          = in_rd && !empty;

   // srv remembers a pop seen during RAISE so the request ends in IDLE, not WAIT.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      srv_next   = srv_reg;
      case (state_reg)
         IDLE: begin
            if (!empty) begin
               state_next = RAISE;
               cnt_next   = '0;
               srv_next   = 1'b0;
            end
         end
         RAISE: begin
            srv_next = srv_reg || pop;
            if (cnt_reg == CW'(IRQ_CYCLES - 1))
               state_next = (srv_reg || pop) ? IDLE : WAIT;
            else
               cnt_next = cnt_reg + 1'b1;
         end
         WAIT: begin
            if (pop)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         srv_reg   <= 1'b0;
         irq_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         srv_reg   <= srv_next;
         irq_reg   <= (state_reg == RAISE);
      end
   end

   assign interrupt = irq_reg;

   // A write is accepted whenever the slot is free or draining this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
         ovf_reg       <= 1'b0;
      end else begin
         if (out_wr && (!out_valid_reg || dev_out_ready)) begin
            out_data_reg  <= out_port;
            out_valid_reg <= 1'b1;
         end else if (out_valid_reg && dev_out_ready) begin
            out_valid_reg <= 1'b0;
         end
         if (out_wr && out_valid_reg && !dev_out_ready)
            ovf_reg <= 1'b1;
      end
   end

   assign dev_out_data  = out_data_reg;
   assign dev_out_valid = out_valid_reg;
   assign out_ovf       = ovf_reg;

endmodule

// File: tb/tb_io_port_controller.sv
// Directed bench for io_port_controller with hand-computed expectations.
module tb_io_port_controller;

   localparam int W = 16;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  dev_in_data;
   logic          dev_in_valid;
   logic          dev_in_ready;
   logic [W-1:0]  in_port;
   logic          in_rd;
   logic          interrupt;
   logic [W-1:0]  out_port;
   logic          out_wr;
   logic [W-1:0]  dev_out_data;
   logic          dev_out_valid;
   logic          dev_out_ready;
   logic          out_ovf;
   logic [2:0]    in_count;

   int vectors = 0;
   int miscompares = 0;

   io_port_controller #(.W(W), .DEPTH(DEPTH), .IRQ_CYCLES(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .dev_in_data   (dev_in_data),
      .dev_in_valid  (dev_in_valid),
      .dev_in_ready  (dev_in_ready),
      .in_port       (in_port),
      .in_rd         (in_rd),
      .interrupt     (interrupt),
      .out_port      (out_port),
      .out_wr        (out_wr),
      .dev_out_data  (dev_out_data),
      .dev_out_valid (dev_out_valid),
      .dev_out_ready (dev_out_ready),
      .out_ovf       (out_ovf),
      .in_count      (in_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      dev_in_data = '0;
      dev_in_valid = 1'b0;
      in_rd = 1'b0;
      out_port = '0;
      out_wr = 1'b0;
      dev_out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // reset state
      check("rst_ready", 32'(dev_in_ready), 32'd1);
      check("rst_in_port", 32'(in_port), 32'h0);
      check("rst_irq", 32'(interrupt), 32'd0);
      check("rst_valid", 32'(dev_out_valid), 32'd0);
      check("rst_data", 32'(dev_out_data), 32'h0);
      check("rst_ovf", 32'(out_ovf), 32'd0);
      check("rst_count", 32'(in_count), 32'd0);

      // single push, interrupt exactly two cycles
      dev_in_data = 16'hA5A5;
      dev_in_valid = 1'b1;
      tick();
      dev_in_valid = 1'b0;
      check("push_head", 32'(in_port), 32'hA5A5);
      check("push_count", 32'(in_count), 32'd1);
      check("irq_n0", 32'(interrupt), 32'd0);
      tick();
      check("irq_n1", 32'(interrupt), 32'd0);
      tick();
      check("irq_n2", 32'(interrupt), 32'd1);
      tick();
      check("irq_n3", 32'(interrupt), 32'd1);
      tick();
      check("irq_n4", 32'(interrupt), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("irq_wait_low", 32'(interrupt), 32'd0);
      end

      // service from WAIT
      in_rd = 1'b1;
      tick();
      in_rd = 1'b0;
      check("svc_head", 32'(in_port), 32'h0);
      check("svc_count", 32'(in_count), 32'd0);
      check("svc_irq", 32'(interrupt), 32'd0);
      tick();
      check("idle_irq", 32'(interrupt), 32'd0);
      in_rd = 1'b1;
      tick();
      in_rd = 1'b0;
      check("rd_empty_count", 32'(in_count), 32'd0);
      check("rd_empty_head", 32'(in_port), 32'h0);

      // fill to full, fifth word held
      dev_in_valid = 1'b1;
      dev_in_data = 16'h0001;
      tick();
      check("fill1_ready", 32'(dev_in_ready), 32'd1);
      dev_in_data = 16'h0002;
      tick();
      dev_in_data = 16'h0003;
      tick();
      check("fill3_irq", 32'(interrupt), 32'd1);
      dev_in_data = 16'h0004;
      tick();
      check("full_ready", 32'(dev_in_ready), 32'd0);
      check("full_count", 32'(in_count), 32'd4);
      check("fill4_irq", 32'(interrupt), 32'd1);
      dev_in_data = 16'h0005;
      tick();
      check("held_count", 32'(in_count), 32'd4);
      check("held_head", 32'(in_port), 32'h0001);
      check("held_irq", 32'(interrupt), 32'd0);

      // drain; word 5 accepted once ready returns
      in_rd = 1'b1;
      tick();
      check("pop1_head", 32'(in_port), 32'h0002);
      check("pop1_count", 32'(in_count), 32'd3);
      check("pop1_ready", 32'(dev_in_ready), 32'd1);
      check("pop1_irq", 32'(interrupt), 32'd0);
      tick();
      dev_in_valid = 1'b0;
      check("pop2_head", 32'(in_port), 32'h0003);
      check("pop2_count", 32'(in_count), 32'd3);
      check("pop2_irq", 32'(interrupt), 32'd0);
      tick();
      check("pop3_head", 32'(in_port), 32'h0004);
      check("pop3_count", 32'(in_count), 32'd2);
      check("pop3_irq", 32'(interrupt), 32'd1);
      tick();
      in_rd = 1'b0;
      check("pop4_head", 32'(in_port), 32'h0005);
      check("pop4_count", 32'(in_count), 32'd1);
      check("pop4_irq", 32'(interrupt), 32'd1);
      tick();
      check("gap_irq", 32'(interrupt), 32'd0);
      tick();
      check("reraise_irq_a", 32'(interrupt), 32'd1);
      tick();
      check("reraise_irq_b", 32'(interrupt), 32'd1);
      tick();
      check("reraise_end", 32'(interrupt), 32'd0);

      // simultaneous push/pop across pointer wrap
      dev_in_valid = 1'b1;
      dev_in_data = 16'h0006;
      tick();
      check("pre_count", 32'(in_count), 32'd2);
      dev_in_data = 16'h0010;
      in_rd = 1'b1;
      tick();
      dev_in_valid = 1'b0;
      check("pp_count", 32'(in_count), 32'd2);
      check("pp_head", 32'(in_port), 32'h0006);
      tick();
      check("wrap_head", 32'(in_port), 32'h0010);
      check("wrap_count", 32'(in_count), 32'd1);
      tick();
      in_rd = 1'b0;
      check("drain_head", 32'(in_port), 32'h0);
      check("drain_count", 32'(in_count), 32'd0);
      for (int i = 0; i < 3; i++) tick();
      check("quiet_irq", 32'(interrupt), 32'd0);

      // outbound register and overflow
      out_port = 16'h1234;
      out_wr = 1'b1;
      tick();
      out_wr = 1'b0;
      check("out_valid", 32'(dev_out_valid), 32'd1);
      check("out_data", 32'(dev_out_data), 32'h1234);
      check("out_ovf0", 32'(out_ovf), 32'd0);
      out_port = 16'h5678;
      out_wr = 1'b1;
      tick();
      out_wr = 1'b0;
      check("drop_data", 32'(dev_out_data), 32'h1234);
      check("drop_ovf", 32'(out_ovf), 32'd1);
      check("drop_valid", 32'(dev_out_valid), 32'd1);
      dev_out_ready = 1'b1;
      tick();
      check("xfer_valid", 32'(dev_out_valid), 32'd0);
      check("xfer_ovf", 32'(out_ovf), 32'd1);
      out_port = 16'h9ABC;
      out_wr = 1'b1;
      tick();
      check("load2_data", 32'(dev_out_data), 32'h9ABC);
      out_port = 16'hDEF0;
      tick();
      out_wr = 1'b0;
      check("xfer_load_valid", 32'(dev_out_valid), 32'd1);
      check("xfer_load_data", 32'(dev_out_data), 32'hDEF0);
      tick();
      check("drain_valid", 32'(dev_out_valid), 32'd0);
      dev_out_ready = 1'b0;

      // reset mid-stream
      out_port = 16'h1111;
      out_wr = 1'b1;
      dev_in_valid = 1'b1;
      dev_in_data = 16'h0007;
      tick();
      out_wr = 1'b0;
      dev_in_data = 16'h0008;
      tick();
      dev_in_data = 16'h0009;
      tick();
      dev_in_valid = 1'b0;
      check("pre_rst_count", 32'(in_count), 32'd3);
      check("pre_rst_irq", 32'(interrupt), 32'd1);
      check("pre_rst_valid", 32'(dev_out_valid), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_count", 32'(in_count), 32'd0);
      check("mrst_irq", 32'(interrupt), 32'd0);
      check("mrst_valid", 32'(dev_out_valid), 32'd0);
      check("mrst_ovf", 32'(out_ovf), 32'd0);
      check("mrst_head", 32'(in_port), 32'h0);
      check("mrst_ready", 32'(dev_in_ready), 32'd1);
      tick();
      check("post_rst_irq", 32'(interrupt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
